// File: rtl/bk_ps2_pkg.sv
// Shared PS/2 definitions for the BK keyboard controller: transmitter states,
// keyboard command/response bytes, LED mask bits and the frame parity helper.
package bk_ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;

    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;

    // Bit positions inside the LED mask byte that follows CMD_SET_LED.
    // CAPS is used as the LAT/RUS indicator.
    localparam int LED_SCROLL = 0;
    localparam int LED_NUM    = 1;
    localparam int LED_CAPS   = 2;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the asynchronous PS/2 clock and data pads into the clk domain and
// flags falling edges of the PS/2 clock. Shared by the transmit and receive paths.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_s,
    output logic dat_s,
    output logic clk_fe
);

    logic [1:0] clk_meta;
    logic [1:0] dat_meta;
    logic       clk_prev;

    // Two-stage synchronizers plus one history bit for edge detection;
    // reset to the idle (high) bus level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta <= 2'b11;
            dat_meta <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_meta <= {clk_meta[0], ps2_clk_i};
            dat_meta <= {dat_meta[0], ps2_dat_i};
            clk_prev <= clk_meta[1];
        end
    end

    assign clk_s  = clk_meta[1];
    assign dat_s  = dat_meta[1];
    assign clk_fe = clk_prev & ~clk_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// clocks out one byte on device clock edges and checks the device ACK.
//
// state     | meaning
// IDLE      | both lines released, waiting for tx_start
// INHIBIT   | holding ps2_clk low before request-to-send
// RTS       | start bit (data low) driven, clock released, waiting for first edge
// DATA      | data/parity/stop shifted on device falling edges, ACK sampled on edge 11
// WAIT_IDLE | ACK seen, waiting for the device to release clock and data
module ps2_host_tx
    import bk_ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout,
    output logic       rx_inhibit
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t    state_q, state_d;
    logic [10:0]      frame_q, frame_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             timeout_q, timeout_d;

    logic clk_s, dat_s, clk_fe;

    ps2_sync_edge u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk_i (ps2_clk_i),
        .ps2_dat_i (ps2_dat_i),
        .clk_s     (clk_s),
        .dat_s     (dat_s),
        .clk_fe    (clk_fe)
    );

    // State, frame, counters and completion pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            frame_q   <= '1;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic. One down-counter serves both the inhibit time and the
    // edge timeout; frame bit 0 is always the bit currently on the data line.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (tx_start && !done_q) begin
                    frame_d   = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
                    bit_cnt_d = '0;
                    cnt_d     = INHIBIT_LOAD;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                // Our own pull-down creates clock edges here; they are ignored.
                if (cnt_q == '0) begin
                    cnt_d   = TIMEOUT_LOAD;
                    state_d = RTS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RTS, DATA: begin
                if (clk_fe) begin
                    cnt_d = TIMEOUT_LOAD;
                    if (state_q == DATA && bit_cnt_q == 4'd10) begin
                        if (!dat_s) begin
                            state_d = WAIT_IDLE;
                        end else begin
                            ack_err_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end else begin
                        frame_d   = {1'b1, frame_q[10:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = DATA;
                    end
                end else if (cnt_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (clk_fe) begin
                    cnt_d = TIMEOUT_LOAD;
                end else if (cnt_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pull-down enables decode straight from registered state, so an
    // asynchronous reset releases both lines immediately.
    assign ps2_clk_oe = (state_q == INHIBIT);
    assign ps2_dat_oe = ((state_q == RTS) || (state_q == DATA)) && !frame_q[0];

    assign tx_busy    = (state_q != IDLE);
    assign rx_inhibit = tx_busy;
    assign tx_done    = done_q;
    assign tx_ack_err = ack_err_q;
    assign tx_timeout = timeout_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, LED mask, 0xFF reset, and so on) from the BK keyboard controller to the attached PS/2 keyboard. It uses the same two-wire open-drain bus the scan-code receive path listens on. The block drives the bus only through active-high pull-low enables; the pads implement the open drain. While a transfer is in progress it raises `rx_inhibit` so the receive path discards the host-generated frame.

## Interface
- `INHIBIT_CYCLES`, 2500: clocks `ps2_clk` is held low before request-to-send (100 µs at 25 MHz).
- `TIMEOUT_CYCLES`, 375000: maximum clocks between device clock falling edges, and from RTS to the first edge (15 ms at 25 MHz).
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_clk_i`  in  1  raw PS/2 clock pad input, asynchronous.
- `ps2_dat_i`  in  1  raw PS/2 data pad input, asynchronous.
- `ps2_clk_oe`  out  1  1 = pull PS/2 clock low.
- `ps2_dat_oe`  out  1  1 = pull PS/2 data low.
- `tx_data`  in  8  byte to send; sampled on the accepted `tx_start`.
- `tx_start`  in  1  single-cycle request; ignored while `tx_busy`=1.
- `tx_busy`  out  1  transfer in progress.
- `tx_done`  out  1  one-cycle pulse: byte sent and device ACK seen.
- `tx_ack_err`  out  1  one-cycle pulse: ACK bit sampled high.
- `tx_timeout`  out  1  one-cycle pulse: device clock edge missing.
- `rx_inhibit`  out  1  equals `tx_busy`.

## Operation
- Reset values: all outputs 0. Both lines released. State IDLE.
- Inputs pass through a 2-FF synchronizer. A falling edge `fe` on `ps2_clk` is one-cycle true when the previous synced value was 1 and the current one is 0.
- IDLE: on `tx_start`, latch `tx_data` and compute odd parity p = ~^tx_data. Go to INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for INHIBIT_CYCLES clocks, then go to RTS.
- RTS: `ps2_dat_oe`=1 (this is the start bit), `ps2_clk_oe`=0, timeout counter cleared. Wait for `fe`.
- Falling edges are counted n = 1..11:
  - n=1..8: drive bit d[n-1], LSB first. `ps2_dat_oe` = ~bit.
  - n=9: drive parity, `ps2_dat_oe` = ~p.
  - n=10: release data (stop bit = 1).
  - n=11: sample `ps2_dat`. If 0, go to WAIT_IDLE. If 1, pulse `tx_ack_err` and go to IDLE.
- WAIT_IDLE: wait until synced clock and data are both 1, then pulse `tx_done` and go to IDLE.
- Timeout counter: cleared on every `fe` and on RTS entry. It runs in RTS, DATA and WAIT_IDLE. Reaching TIMEOUT_CYCLES releases both lines, pulses `tx_timeout` and returns to IDLE.
- Error pulses (`tx_ack_err`, `tx_timeout`) and `tx_done` are mutually exclusive per transfer.
- `tx_start` while busy: dropped, with no queueing.
- `tx_start` in the same cycle as `tx_done`: dropped. It is accepted from the next cycle.
- Reset mid-transfer: lines release immediately (asynchronously), with no completion pulse.
- `fe` events that occur during INHIBIT are ignored. Only this block is driving the clock low then.

## Timing
- Accepted `tx_start` to `ps2_clk_oe`=1: 1 clock. `tx_busy` rises in the same cycle.
- `ps2_clk_oe` is high for exactly INHIBIT_CYCLES clocks. `ps2_dat_oe` rises in the same cycle `ps2_clk_oe` falls.
- Data change: 1 clock after the synced `fe`, which is 3 clocks after the pad edge. This is well inside the device's clock-low half-period.
- ACK sample: taken in the cycle `fe` n=11 is registered.
- Completion pulses last 1 clock. `tx_busy` falls in the same cycle.

## Structure
- Package `bk_ps2_pkg` holds:
  - The state enum: IDLE, INHIBIT, RTS, DATA, WAIT_IDLE.
  - Command constants: CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4.
  - Response constants: RSP_ACK=8'hFA, RSP_RESEND=8'hFE.
  - LED bit positions: SCROLL=0, NUM=1, CAPS=2. CAPS reflects LAT/RUS.
- Sub-module `ps2_sync_edge`: 2-FF synchronizer plus falling-edge detector. The receive path reuses it.
- Inside the module: an 11-bit frame shift register, a 4-bit edge counter, and one counter wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

## Test plan
All scenarios use INHIBIT_CYCLES=4 and TIMEOUT_CYCLES=200, with a behavioural device model clocking at a 20-clock half-period.
- Send 0xED, device ACKs with data 0 → lines sampled at rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1; one `tx_done` pulse; `ps2_clk_oe` high for exactly 4 clocks.
- Send 0x07 → parity 0; send 0x00 → parity 1; both end with `tx_done`.
- Device leaves data high at edge 11 → `tx_ack_err` pulse, no `tx_done`, both oe=0, `tx_busy`=0.
- Device never clocks after RTS → `tx_timeout` exactly 200 clocks after RTS entry, both lines released.
- `tx_start` with 0x55 during a 0xED transfer → ignored; the frame carries 0xED only; a new `tx_start` right after `tx_done` is accepted.
- Assert `reset_n`=0 at edge 5 → `ps2_clk_oe`=`ps2_dat_oe`=0 with no clock edge needed, no pulses; after release, a new 0xF4 transfer completes.
